// File: rtl/retire_pair_checker.sv
// Lockstep retirement pair checker: captures the selected RVFI port of each core on an
// aligned retire pulse, then compares PC/insn and tracks counters. Optional watchdog: RETIRE_CHK_WATCHDOG_EN.
module retire_pair_checker #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MAX_RETIRE  = 0,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              retire_i,
  input  logic              sel_1_i,
  input  logic              sel_2_i,
  input  logic              valid_1_1_i,
  input  logic              valid_1_2_i,
  input  logic              valid_2_1_i,
  input  logic              valid_2_2_i,
  input  logic [XLEN-1:0]   pc_rdata_1_1_i,
  input  logic [XLEN-1:0]   pc_rdata_1_2_i,
  input  logic [XLEN-1:0]   pc_rdata_2_1_i,
  input  logic [XLEN-1:0]   pc_rdata_2_2_i,
  input  logic [31:0]       insn_1_1_i,
  input  logic [31:0]       insn_1_2_i,
  input  logic [31:0]       insn_2_1_i,
  input  logic [31:0]       insn_2_2_i,
  output logic              mismatch_o,
  output logic [2:0]        mismatch_code_o,
  output logic              violation_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  retire_count_o,
  output logic [CNT_W-1:0]  mismatch_count_o,
  output logic [XLEN-1:0]   first_pc_1_o,
  output logic [XLEN-1:0]   first_pc_2_o,
  output logic              stall_o
);

  localparam int unsigned INSN_W = 32;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_VIOLATED = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  logic [1:0]        state_q, state_d;

  logic              cap_vld_q;
  logic              cap_ok_1_q, cap_ok_2_q;
  logic [XLEN-1:0]   cap_pc_1_q, cap_pc_2_q;
  logic [INSN_W-1:0] cap_insn_1_q, cap_insn_2_q;

  logic              sel_ok_1_c, sel_ok_2_c;
  logic [XLEN-1:0]   sel_pc_1_c, sel_pc_2_c;
  logic [INSN_W-1:0] sel_insn_1_c, sel_insn_2_c;

  logic [2:0]        code_c;
  logic              fail_c;
  logic [CNT_W-1:0]  cnt_inc_c;
  logic              hit_max_c;
  logic              capture_c;

  // Port select; unselected ports never reach the capture registers.
  always_comb begin
    sel_ok_1_c   = sel_1_i ? valid_1_2_i    : valid_1_1_i;
    sel_pc_1_c   = sel_1_i ? pc_rdata_1_2_i : pc_rdata_1_1_i;
    sel_insn_1_c = sel_1_i ? insn_1_2_i     : insn_1_1_i;
    sel_ok_2_c   = sel_2_i ? valid_2_2_i    : valid_2_1_i;
    sel_pc_2_c   = sel_2_i ? pc_rdata_2_2_i : pc_rdata_2_1_i;
    sel_insn_2_c = sel_2_i ? insn_2_2_i     : insn_2_1_i;
  end

  // Compare stage and next-state logic.
  always_comb begin
    code_c    = 3'b000;
    code_c[2] = !(cap_ok_1_q && cap_ok_2_q);
    if (!code_c[2]) begin
      code_c[0] = (cap_pc_1_q != cap_pc_2_q);
      code_c[1] = (cap_insn_1_q != cap_insn_2_q);
    end
    fail_c    = cap_vld_q && (code_c != 3'b000);
    cnt_inc_c = retire_count_o + CNT_W'(1);
    hit_max_c = (MAX_RETIRE != 0) && cap_vld_q && (cnt_inc_c == CNT_W'(MAX_RETIRE));
    capture_c = retire_i && (state_q != S_DONE) && !hit_max_c;

    state_d = state_q;
    case (state_q)
      S_IDLE:     if (capture_c) state_d = S_RUN;
      S_RUN:      if (fail_c)    state_d = S_VIOLATED;
      S_VIOLATED: state_d = S_VIOLATED;
      S_DONE:     state_d = S_DONE;
      default:    state_d = S_IDLE;
    endcase
    if (hit_max_c) state_d = S_DONE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Capture stage; a pair dropped at the DONE edge clears the stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cap_vld_q    <= 1'b0;
      cap_ok_1_q   <= 1'b0;
      cap_ok_2_q   <= 1'b0;
      cap_pc_1_q   <= '0;
      cap_pc_2_q   <= '0;
      cap_insn_1_q <= '0;
      cap_insn_2_q <= '0;
    end else begin
      cap_vld_q <= capture_c;
      if (capture_c) begin
        cap_ok_1_q   <= sel_ok_1_c;
        cap_ok_2_q   <= sel_ok_2_c;
        cap_pc_1_q   <= sel_pc_1_c;
        cap_pc_2_q   <= sel_pc_2_c;
        cap_insn_1_q <= sel_insn_1_c;
        cap_insn_2_q <= sel_insn_2_c;
      end
    end
  end

  // Result registers, counters and first-mismatch record.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mismatch_o       <= 1'b0;
      mismatch_code_o  <= 3'b000;
      violation_o      <= 1'b0;
      done_o           <= 1'b0;
      retire_count_o   <= '0;
      mismatch_count_o <= '0;
      first_pc_1_o     <= '0;
      first_pc_2_o     <= '0;
    end else begin
      mismatch_o <= fail_c;
      done_o     <= done_o | hit_max_c;
      if (cap_vld_q) begin
        retire_count_o  <= cnt_inc_c;
        mismatch_code_o <= code_c;
      end
      if (fail_c) begin
        if (mismatch_count_o != '1) mismatch_count_o <= mismatch_count_o + CNT_W'(1);
        if (!violation_o) begin
          first_pc_1_o <= cap_pc_1_q;
          first_pc_2_o <= cap_pc_2_q;
        end
        violation_o <= 1'b1;
      end
    end
  end

`ifdef RETIRE_CHK_WATCHDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_q;
  logic              wdog_act_c;

  assign wdog_act_c = (state_q == S_RUN) || (state_q == S_VIOLATED);

  // Idle-cycle watchdog: saturates at the limit, stall is sticky.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q  <= '0;
      stall_o <= 1'b0;
    end else if (wdog_act_c) begin
      if (retire_i) begin
        wdog_q <= '0;
      end else if (wdog_q != WDOG_W'(WDOG_CYCLES)) begin
        wdog_q <= wdog_q + WDOG_W'(1);
        if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) stall_o <= 1'b1;
      end
    end
  end
`else
  assign stall_o = 1'b0;
`endif

endmodule

// File: doc/retire_pair_checker.md
Name: retire_pair_checker

Overview:
- Consumer side of the two-core retirement lockstep interface. Sits downstream of the clock synchroniser that pauses core 1 and core 2 and issues retire/sel pulses.
- On each aligned retirement it selects the indicated RVFI port from each core and registers the pair. It then compares PC and instruction word, and maintains retirement/mismatch counters and a sticky violation flag for the formal/relational harness.

Parameters:
- XLEN, 32, width of pc_rdata and insn fields.
- CNT_W, 32, width of retirement and mismatch counters.
- MAX_RETIRE, 0, retirement count at which checking stops (DONE); 0 = unlimited.
- WDOG_CYCLES, 64, watchdog limit (optional feature only).

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- retire_i  in  1  aligned retirement pulse from the synchroniser.
- sel_1_i  in  1  core-1 port select: 0 = port 1, 1 = port 2.
- sel_2_i  in  1  core-2 port select.
- valid_1_1_i, valid_1_2_i, valid_2_1_i, valid_2_2_i  in  1 each  RVFI valid per core/port.
- pc_rdata_1_1_i, pc_rdata_1_2_i, pc_rdata_2_1_i, pc_rdata_2_2_i  in  XLEN each  retired PC.
- insn_1_1_i, insn_1_2_i, insn_2_1_i, insn_2_2_i  in  32 each  retired instruction word.
- mismatch_o  out  1  one-cycle pulse on a failing compare.
- mismatch_code_o  out  3  bit0 = PC differs, bit1 = insn differs, bit2 = protocol error (selected port not valid).
- violation_o  out  1  sticky: any mismatch since reset.
- done_o  out  1  MAX_RETIRE reached.
- retire_count_o  out  CNT_W  compared retirements.
- mismatch_count_o  out  CNT_W  failing compares; saturates.
- first_pc_1_o, first_pc_2_o  out  XLEN  PC pair of the first mismatch.
- stall_o  out  1  watchdog flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (async, rst_ni = 0): all outputs 0, state IDLE, capture stage empty.
- Stage 1 capture, posedge with retire_i = 1 and state not DONE/VIOLATED-halted:
  - Register the selected valid, PC and insn of each core. Core n uses port 1 when sel_n_i = 0, port 2 when sel_n_i = 1.
  - Set cap_vld.
- Stage 2 compare, the cycle after capture (latency: retire_i edge -> mismatch_o / count update = 1 cycle):
  - code[2] = !sel_valid_1 | !sel_valid_2.
  - code[0] = pc1 != pc2, evaluated only if code[2] = 0.
  - code[1] = insn1 != insn2, evaluated only if code[2] = 0.
  - Any code bit set -> mismatch_o = 1 for one cycle, mismatch_code_o = code, mismatch_count_o += 1 (saturate at all-ones).
  - retire_count_o += 1 on every compare, including failing ones; wraps modulo 2^CNT_W.
  - mismatch_code_o holds its last value until the next compare.
- States:
  - IDLE -> RUN on first capture.
  - RUN -> VIOLATED on first mismatch: latch first_pc_1_o/first_pc_2_o and set violation_o. Later mismatches keep counting; first_pc_* are never overwritten.
  - RUN or VIOLATED -> DONE when MAX_RETIRE != 0 and retire_count_o reaches MAX_RETIRE after the increment. done_o = 1; further retire_i ignored; counters frozen.
  - DONE is terminal until reset. violation_o stays visible in DONE.
- Back-to-back retire_i on consecutive cycles: full throughput; one compare per cycle.
- retire_i while an earlier capture is still comparing: both are processed in pipeline order.
- retire_i in the same cycle as the DONE transition: dropped.
- Reset mid-pipeline discards the captured pair.
- X on unselected ports must not affect results.

Optional Feature:
- Macro RETIRE_CHK_WATCHDOG_EN.
- When defined, in RUN or VIOLATED a cycle counter increments on every cycle without retire_i and clears on retire_i.
- Reaching WDOG_CYCLES sets stall_o, which is sticky until reset; the counter saturates.
- When undefined, stall_o is tied 0 and the counter logic is absent.

Test Plan:
- Reset with rst_ni = 0 mid-stream, release -> all outputs 0 and state IDLE; first retire_i afterwards gives retire_count_o = 1.
- 10 retire pulses with sel_1 = 0, sel_2 = 1, pc_1_1 = pc_2_2 = 0x80000000 + 4k, equal insn -> retire_count_o = 10, mismatch_o never high, violation_o = 0.
- Retire with pc_1_1 = 0x100, pc_2_1 = 0x104, equal insn -> one cycle later mismatch_o = 1, code = 3'b001, first_pc_1_o = 0x100, first_pc_2_o = 0x104, violation_o = 1. A second mismatch at 0x200 leaves first_pc_* unchanged and gives mismatch_count_o = 2.
- Retire with sel_2 = 1 but valid_2_2 = 0 -> code = 3'b100, protocol mismatch counted, PC/insn compare suppressed.
- MAX_RETIRE = 4, 6 consecutive retire pulses -> done_o = 1 one cycle after the 4th pulse; retire_count_o stays 4.
- With RETIRE_CHK_WATCHDOG_EN and WDOG_CYCLES = 8: one retire, then 8 idle cycles -> stall_o = 1. Without the macro -> stall_o stays 0.
